// File: rtl/chnl_rx_buffer_if.sv
// Channel receive buffer bus: upstream valid/ready handshake, downstream pop
// port, and the register-block facing status (enable, margin, stall stats).
interface chnl_rx_buffer_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 32,
    parameter int SW    = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          ch_en;
    logic [DW-1:0] ch_data;
    logic          ch_valid;
    logic          ch_ready;
    logic          rcv_vld;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW:0]   margin;
    logic          stall_clr;
    logic [SW-1:0] stall_cnt;

    // Driver side: upstream channel, downstream arbiter and register block.
    modport master (
        output ch_en, ch_data, ch_valid, rd_en, stall_clr,
        input  ch_ready, rcv_vld, rd_data, rd_valid, margin, stall_cnt
    );

    // Buffer side.
    modport slave (
        input  ch_en, ch_data, ch_valid, rd_en, stall_clr,
        output ch_ready, rcv_vld, rd_data, rd_valid, margin, stall_cnt
    );
endinterface

// File: rtl/chnl_rx_buffer.sv
// Channel receive buffer: accepts words from one upstream channel through a
// valid/ready handshake into a show-ahead FIFO, drained by a pop interface.
// Reports free space and a saturating count of backpressure stall cycles.
module chnl_rx_buffer #(
    parameter int DW    = 8,
    parameter int DEPTH = 32,
    parameter int SW    = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input logic             clk,
    input logic             rstn,
    chnl_rx_buffer_if.slave bus
);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        if (v == {SW{1'b1}}) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    // Handshake and status decode, all from registered state (no valid-to-ready path).
    always_comb begin
        bus.ch_ready = bus.ch_en & (count != FULL_CNT);
        bus.rd_valid = (count != '0);
        push         = bus.ch_valid & bus.ch_ready;
        pop          = bus.rd_en & bus.rd_valid;
        bus.margin   = FULL_CNT - count;
        bus.rd_data  = mem[rptr];
    end

    // Pointers, occupancy and accept strobe; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            bus.rcv_vld <= 1'b0;
        end else begin
            bus.rcv_vld <= push;
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= bus.ch_data;
        end
    end

    // Stall statistics: clear wins over increment, increment saturates.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.stall_cnt <= '0;
        end else if (bus.stall_clr) begin
            bus.stall_cnt <= '0;
        end else if (bus.ch_valid && !bus.ch_ready) begin
            bus.stall_cnt <= sat_inc(bus.stall_cnt);
        end
    end
endmodule

// File: tb/tb_chnl_rx_buffer.sv
// Directed testbench for chnl_rx_buffer: a DEPTH=32/SW=16 instance for the
// FIFO behaviour and a DEPTH=4/SW=4 instance for stall counter saturation.
module tb_chnl_rx_buffer;
    logic clk;
    logic rstn;
    int   errors;
    int   checks;

    chnl_rx_buffer_if #(.DW(8), .DEPTH(32), .SW(16)) bus ();
    chnl_rx_buffer_if #(.DW(8), .DEPTH(4),  .SW(4))  bus4 ();

    chnl_rx_buffer #(.DW(8), .DEPTH(32), .SW(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    chnl_rx_buffer #(.DW(8), .DEPTH(4), .SW(4)) dut4 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] f(input int j);
        return 8'(j * 7 + 3);
    endfunction

    task automatic test_reset();
        rstn = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (bus.ch_ready !== 1'b1) begin errors++; $display("FAIL reset_ch_ready got=%b exp=1", bus.ch_ready); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
        checks++; if (bus.margin !== 6'd32) begin errors++; $display("FAIL reset_margin got=%0d exp=32", bus.margin); end
        checks++; if (bus.rcv_vld !== 1'b0) begin errors++; $display("FAIL reset_rcv_vld got=%b exp=0", bus.rcv_vld); end
        checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", bus.stall_cnt); end
        checks++; if (bus4.margin !== 3'd4) begin errors++; $display("FAIL reset_margin4 got=%0d exp=4", bus4.margin); end
        bus.ch_en = 1'b0;
        #1;
        checks++; if (bus.ch_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_follows_en got=%b exp=0", bus.ch_ready); end
        bus.ch_en = 1'b1;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_push3();
        logic [7:0] w [3];
        w = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            bus.ch_valid = 1'b1;
            bus.ch_data  = w[i];
            #1;
            checks++; if (bus.ch_ready !== 1'b1) begin errors++; $display("FAIL push3_ready[%0d] got=%b exp=1", i, bus.ch_ready); end
            checks++; if (bus.rcv_vld !== (i != 0)) begin errors++; $display("FAIL push3_rcv_vld[%0d] got=%b exp=%b", i, bus.rcv_vld, (i != 0)); end
            checks++; if (bus.margin !== 6'(32 - i)) begin errors++; $display("FAIL push3_margin[%0d] got=%0d exp=%0d", i, bus.margin, 32 - i); end
            tick();
        end
        bus.ch_valid = 1'b0;
        #1;
        checks++; if (bus.rcv_vld !== 1'b1) begin errors++; $display("FAIL push3_rcv_vld_last got=%b exp=1", bus.rcv_vld); end
        checks++; if (bus.margin !== 6'd29) begin errors++; $display("FAIL push3_margin_end got=%0d exp=29", bus.margin); end
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL push3_rd_valid got=%b exp=1", bus.rd_valid); end
        checks++; if (bus.rd_data !== 8'h11) begin errors++; $display("FAIL push3_head got=%h exp=11", bus.rd_data); end
        tick();
        checks++; if (bus.rcv_vld !== 1'b0) begin errors++; $display("FAIL push3_rcv_vld_drop got=%b exp=0", bus.rcv_vld); end
        for (int i = 0; i < 3; i++) begin
            bus.rd_en = 1'b1;
            #1;
            checks++; if (bus.rd_data !== w[i]) begin errors++; $display("FAIL push3_drain[%0d] got=%h exp=%h", i, bus.rd_data, w[i]); end
            tick();
        end
        bus.rd_en = 1'b0;
        #1;
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL push3_empty got=%b exp=0", bus.rd_valid); end
        checks++; if (bus.margin !== 6'd32) begin errors++; $display("FAIL push3_margin_drained got=%0d exp=32", bus.margin); end
    endtask

    task automatic test_full();
        bus.stall_clr = 1'b1;
        tick();
        bus.stall_clr = 1'b0;
        checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL full_stall_clr got=%0d exp=0", bus.stall_cnt); end
        for (int i = 0; i < 32; i++) begin
            bus.ch_valid = 1'b1;
            bus.ch_data  = 8'(i);
            #1;
            checks++; if (bus.ch_ready !== 1'b1) begin errors++; $display("FAIL full_fill_ready[%0d] got=%b exp=1", i, bus.ch_ready); end
            tick();
        end
        bus.ch_data = 8'd32;
        #1;
        checks++; if (bus.ch_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", bus.ch_ready); end
        checks++; if (bus.margin !== 6'd0) begin errors++; $display("FAIL full_margin got=%0d exp=0", bus.margin); end
        repeat (3) tick();
        checks++; if (bus.stall_cnt !== 16'd3) begin errors++; $display("FAIL full_stall_cnt got=%0d exp=3", bus.stall_cnt); end
        bus.rd_en = 1'b1;
        #1;
        checks++; if (bus.rd_data !== 8'd0) begin errors++; $display("FAIL full_pop_head got=%h exp=00", bus.rd_data); end
        tick();
        bus.rd_en = 1'b0;
        #1;
        checks++; if (bus.ch_ready !== 1'b1) begin errors++; $display("FAIL full_refill_ready got=%b exp=1", bus.ch_ready); end
        checks++; if (bus.margin !== 6'd1) begin errors++; $display("FAIL full_refill_margin got=%0d exp=1", bus.margin); end
        checks++; if (bus.stall_cnt !== 16'd4) begin errors++; $display("FAIL full_stall_after_pop got=%0d exp=4", bus.stall_cnt); end
        tick();
        bus.ch_valid = 1'b0;
        #1;
        checks++; if (bus.ch_ready !== 1'b0) begin errors++; $display("FAIL full_word33_ready got=%b exp=0", bus.ch_ready); end
        checks++; if (bus.stall_cnt !== 16'd4) begin errors++; $display("FAIL full_stall_hold got=%0d exp=4", bus.stall_cnt); end
        for (int i = 1; i <= 32; i++) begin
            bus.rd_en = 1'b1;
            #1;
            checks++; if (bus.rd_data !== 8'(i)) begin errors++; $display("FAIL full_drain[%0d] got=%h exp=%h", i, bus.rd_data, 8'(i)); end
            tick();
        end
        bus.rd_en = 1'b0;
        #1;
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL full_drained got=%b exp=0", bus.rd_valid); end
    endtask

    task automatic test_same_cycle();
        bus.ch_valid = 1'b1;
        bus.ch_data  = 8'hA5;
        bus.rd_en    = 1'b1;
        #1;
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL same_pre_valid got=%b exp=0", bus.rd_valid); end
        tick();
        bus.ch_valid = 1'b0;
        bus.rd_en    = 1'b0;
        #1;
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL same_rd_valid got=%b exp=1", bus.rd_valid); end
        checks++; if (bus.rd_data !== 8'hA5) begin errors++; $display("FAIL same_rd_data got=%h exp=a5", bus.rd_data); end
        checks++; if (bus.margin !== 6'd31) begin errors++; $display("FAIL same_margin got=%0d exp=31", bus.margin); end
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.ch_valid = 1'b1;
        bus.ch_data  = f(0);
        tick();
        for (int i = 0; i < 96; i++) begin
            bus.ch_data = f(i + 1);
            bus.rd_en   = 1'b1;
            #1;
            checks++; if (bus.rd_data !== f(i)) begin errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, bus.rd_data, f(i)); end
            checks++; if (bus.margin !== 6'd31) begin errors++; $display("FAIL stream_margin[%0d] got=%0d exp=31", i, bus.margin); end
            tick();
        end
        bus.ch_valid = 1'b0;
        #1;
        checks++; if (bus.rd_data !== f(96)) begin errors++; $display("FAIL stream_last got=%h exp=%h", bus.rd_data, f(96)); end
        tick();
        bus.rd_en = 1'b0;
        #1;
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL stream_empty got=%b exp=0", bus.rd_valid); end
    endtask

    task automatic test_ch_en();
        bus.stall_clr = 1'b1;
        tick();
        bus.stall_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.ch_valid = 1'b1;
            bus.ch_data  = 8'(8'h50 + i);
            tick();
        end
        bus.ch_en   = 1'b0;
        bus.ch_data = 8'h99;
        #1;
        checks++; if (bus.ch_ready !== 1'b0) begin errors++; $display("FAIL en_ready_drop got=%b exp=0", bus.ch_ready); end
        checks++; if (bus.margin !== 6'd27) begin errors++; $display("FAIL en_margin got=%0d exp=27", bus.margin); end
        for (int i = 0; i < 5; i++) begin
            bus.rd_en = 1'b1;
            #1;
            checks++; if (bus.rd_data !== 8'(8'h50 + i)) begin errors++; $display("FAIL en_drain[%0d] got=%h exp=%h", i, bus.rd_data, 8'(8'h50 + i)); end
            tick();
        end
        bus.rd_en = 1'b0;
        #1;
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL en_drained got=%b exp=0", bus.rd_valid); end
        checks++; if (bus.margin !== 6'd32) begin errors++; $display("FAIL en_no_push got=%0d exp=32", bus.margin); end
        checks++; if (bus.stall_cnt !== 16'd5) begin errors++; $display("FAIL en_stall_cnt got=%0d exp=5", bus.stall_cnt); end
        bus.stall_clr = 1'b1;
        tick();
        bus.stall_clr = 1'b0;
        checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL en_clr_priority got=%0d exp=0", bus.stall_cnt); end
        tick();
        checks++; if (bus.stall_cnt !== 16'd1) begin errors++; $display("FAIL en_stall_resume got=%0d exp=1", bus.stall_cnt); end
        bus.ch_valid = 1'b0;
        bus.ch_en    = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) begin
            bus.ch_valid = 1'b1;
            bus.ch_data  = 8'(8'h60 + i);
            tick();
        end
        checks++; if (bus.margin !== 6'd22) begin errors++; $display("FAIL rstmid_pre_margin got=%0d exp=22", bus.margin); end
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rd_valid got=%b exp=0", bus.rd_valid); end
        checks++; if (bus.margin !== 6'd32) begin errors++; $display("FAIL rstmid_margin got=%0d exp=32", bus.margin); end
        checks++; if (bus.rcv_vld !== 1'b0) begin errors++; $display("FAIL rstmid_rcv_vld got=%b exp=0", bus.rcv_vld); end
        checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_stall got=%0d exp=0", bus.stall_cnt); end
        bus.ch_valid = 1'b0;
        tick();
        rstn = 1'b1;
        bus.ch_valid = 1'b1;
        bus.ch_data  = 8'h77;
        #1;
        checks++; if (bus.ch_ready !== 1'b1) begin errors++; $display("FAIL rstmid_post_ready got=%b exp=1", bus.ch_ready); end
        tick();
        bus.ch_valid = 1'b0;
        #1;
        checks++; if (bus.rd_data !== 8'h77) begin errors++; $display("FAIL rstmid_post_data got=%h exp=77", bus.rd_data); end
        checks++; if (bus.margin !== 6'd31) begin errors++; $display("FAIL rstmid_post_margin got=%0d exp=31", bus.margin); end
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic test_saturate();
        bus4.ch_en    = 1'b0;
        bus4.ch_valid = 1'b1;
        repeat (14) tick();
        checks++; if (bus4.stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_pre got=%0d exp=14", bus4.stall_cnt); end
        repeat (6) tick();
        checks++; if (bus4.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", bus4.stall_cnt); end
        bus4.ch_valid = 1'b0;
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        rstn           = 1'b1;
        bus.ch_en      = 1'b1;
        bus.ch_data    = '0;
        bus.ch_valid   = 1'b0;
        bus.rd_en      = 1'b0;
        bus.stall_clr  = 1'b0;
        bus4.ch_en     = 1'b0;
        bus4.ch_data   = '0;
        bus4.ch_valid  = 1'b0;
        bus4.rd_en     = 1'b0;
        bus4.stall_clr = 1'b0;
        test_reset();
        test_push3();
        test_full();
        test_same_cycle();
        test_back_to_back();
        test_ch_en();
        test_reset_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/chnl_rx_buffer.md
Name: chnl_rx_buffer

Overview:
Parametrised channel receive buffer for the MCDF datapath. It terminates one upstream channel using a valid/ready handshake (ch_data, ch_valid, ch_ready, rcv_vld) and stores accepted words in a show-ahead FIFO. The downstream arbiter drains the FIFO through a pop interface. It reports free space (margin) for the register block and counts backpressure stall cycles. It generalises the fixed 8-bit channel to configurable data width and depth, and adds a channel enable, margin reporting and stall statistics.

Parameters:
DW, 8, channel data width in bits (1..64).
DEPTH, 32, FIFO depth in words; must be a power of two, minimum 2.
AW, $clog2(DEPTH), derived pointer width; never overridden.
SW, 16, stall counter width.

Ports:
clk  input  1  system clock; all logic on posedge.
rstn  input  1  asynchronous active-low reset.
ch_en  input  1  channel enable from the register block.
ch_data  input  DW  upstream write data.
ch_valid  input  1  upstream data valid.
ch_ready  output  1  buffer can accept a word this cycle.
rcv_vld  output  1  registered strobe; high one cycle after each accepted word.
rd_en  input  1  downstream pop request.
rd_data  output  DW  head-of-FIFO word (show-ahead).
rd_valid  output  1  FIFO not empty.
margin  output  AW+1  free slots, DEPTH - count.
stall_clr  input  1  synchronous clear of stall_cnt.
stall_cnt  output  SW  saturating count of cycles with ch_valid=1 and ch_ready=0.

Behaviour:
- Reset (rstn=0, async): wptr=rptr=0, count=0, rcv_vld=0, stall_cnt=0, margin=DEPTH, rd_valid=0. ch_ready follows ch_en (FIFO empty). rd_data is don't-care while rd_valid=0. Memory contents are not reset.
- ch_ready = ch_en & (count != DEPTH). This is combinational from registered state only; there is no path from ch_valid to ch_ready.
- push = ch_valid & ch_ready. On push: mem[wptr] <= ch_data, wptr increments and wraps modulo DEPTH.
- pop = rd_en & rd_valid. On pop: rptr increments and wraps modulo DEPTH. rd_en while empty is ignored, with no state change.
- count next-state: +1 on push only, -1 on pop only, unchanged when push and pop occur together or when neither occurs.
- When full, push is impossible because ch_ready=0. A pop in that cycle raises ch_ready in the next cycle (1-cycle refill latency).
- When empty, a push and an rd_en in the same cycle: the push lands and the pop is ignored. rd_valid rises the next cycle with rd_data equal to the pushed word (write-to-read latency 1).
- rd_data = mem[rptr], valid whenever rd_valid=1 (FWFT). rd_valid = (count != 0).
- margin = DEPTH - count, derived from registered count; it updates the cycle after a push or pop.
- rcv_vld is registered: rcv_vld <= push.
- stall_cnt: if stall_clr, it loads 0, and stall_clr takes priority over increment. Otherwise it increments when ch_valid & ~ch_ready and holds at 2^SW-1 (saturating, no wrap).
- ch_en=0: ch_ready drops in the same cycle and no further pushes occur. Stored data is retained and stays drainable through rd_en. A held ch_valid counts as a stall.
- Reset asserted mid-transfer: all state clears immediately and buffered data is discarded. The first cycle after rstn deasserts behaves as post-reset empty.

Test Plan:
1. Reset, ch_en=1, push 0x11,0x22,0x33 back-to-back with no pops -> ch_ready=1 throughout; rcv_vld high for 3 cycles, lagging 1 cycle; margin 32→29; rd_data=0x11, rd_valid=1.
2. Fill DEPTH=32 words with rd_en=0 and ch_valid held -> ch_ready=0 after the 32nd accept; margin=0; stall_cnt increments every subsequent cycle. One pop -> ch_ready=1 the next cycle and word 33 is accepted.
3. Empty FIFO, same-cycle push 0xA5 and rd_en=1 -> no pop; next cycle rd_valid=1, rd_data=0xA5, margin=31.
4. Continuous push and pop at full rate across 3×DEPTH words -> output order matches input order exactly through pointer wrap; count stays constant.
5. Drop ch_en with 5 words stored -> ch_ready=0 the same cycle; all 5 words drain in order via rd_en; stall_cnt counts the held ch_valid cycles. stall_clr together with a stall cycle -> stall_cnt=0.
6. Assert rstn=0 mid-burst with 10 words stored -> rd_valid=0 and margin=32 immediately. With SW=4, 20 stall cycles -> stall_cnt=15 (saturated).
